ltssm_polling_seq: RTL and testbench
====================================

// Module: ltssm_polling_seq
// PURPOSE
// Sequences the LTSSM Polling sub-states (Polling.Active, Polling.Configuration) for one lane.
// Started by the LTSSM controller on leaving DETECT. Drives TS1/TS2 ordered-set requests to the PHY TX.
// Counts received TS1/TS2 from the PHY RX. Reports success (go to CONFIGURATION) or timeout (back to DETECT).
// PARAMETERS
// TX_TS1_MIN      1024      min TS1s accepted by TX in ACTIVE before exit allowed
// RX_CONSEC       8         consecutive qualifying OSs required to exit ACTIVE / CONFIG
// TX_TS2_AFTER    16        TS2s accepted by TX after first TS2 received, required to exit CONFIG
// ACTIVE_TIMEOUT  6000000   cycles in ACTIVE before timeout (24 ms @ 250 MHz)
// CONFIG_TIMEOUT  12000000  cycles in CONFIG before timeout (48 ms @ 250 MHz)
// PORTS
// clk_i          in   1   clock; single clock domain
// rst_i          in   1   synchronous active-high reset
// start_i        in   1   level/pulse from LTSSM; sampled only in IDLE
// os_tx_valid_o  out  1   request PHY TX to send one ordered set
// os_tx_ts2_o    out  1   0 = TS1, 1 = TS2; valid while os_tx_valid_o
// os_tx_ready_i  in   1   PHY TX accepts OS this cycle (handshake = valid & ready)
// rx_os_valid_i  in   1   PHY RX delivered one decoded OS this cycle
// rx_os_type_i   in   2   00 other/invalid, 01 TS1, 10 TS2, 11 other/invalid
// state_o        out  2   0 IDLE, 1 ACTIVE, 2 CONFIG (3 never driven)
// done_o         out  1   1-cycle pulse: Polling complete, enter CONFIGURATION
// timeout_o      out  1   1-cycle pulse: Polling timed out, return to DETECT
// BEHAVIOUR
// - Reset (rst_i=1 at clk edge): state IDLE; all outputs 0; all counters and timer 0. Reset mid-run aborts immediately.
// - All outputs are registered. Counter widths are $clog2(param+1). tx counters saturate at their limit.
// - IDLE: os_tx_valid_o=0. start_i=1 -> ACTIVE next cycle, with os_tx_valid_o=1 in that first cycle.
//   On entry, tx/rx counters and timer are cleared. start_i is ignored outside IDLE.
// - ACTIVE: os_tx_valid_o=1, os_tx_ts2_o=0.
//   - tx1_cnt += 1 on each handshake.
//   - rx_cnt += 1 on rx_os_valid_i with type TS1 or TS2; reset to 0 on rx_os_valid_i with type 00/11.
//   - No rx_os_valid_i: rx_cnt holds.
//   - Exit to CONFIG when tx1_cnt>=TX_TS1_MIN and rx_cnt>=RX_CONSEC, taken only in a handshake cycle,
//     so os_tx_ts2_o never changes while valid is pending.
// - CONFIG: os_tx_valid_o=1, os_tx_ts2_o=1.
//   - rx_cnt += 1 on rx TS2; reset to 0 on any other valid rx OS.
//   - seen_ts2 sets on first rx TS2. tx2_cnt += 1 on each handshake only while seen_ts2 is already set.
//   - Exit when rx_cnt>=RX_CONSEC and tx2_cnt>=TX_TS2_AFTER, in a handshake cycle:
//     IDLE next cycle, done_o=1 that cycle.
// - Timer: cleared on every state entry; increments each cycle in ACTIVE/CONFIG.
//   - timer==ACTIVE_TIMEOUT-1 (ACTIVE) or CONFIG_TIMEOUT-1 (CONFIG) -> IDLE next cycle, timeout_o=1,
//     os_tx_valid_o=0, even with a handshake pending (abort allowed).
// - Simultaneous events:
//   - Exit and timeout in the same cycle: exit wins.
//   - An rx OS in the ACTIVE->CONFIG transition cycle is discarded; CONFIG counters start at 0.
// - done_o and timeout_o are mutually exclusive and never high for more than 1 cycle.
// TESTING (params: TX_TS1_MIN=4, RX_CONSEC=2, TX_TS2_AFTER=3, ACTIVE_TIMEOUT=50, CONFIG_TIMEOUT=60)
// - Reset, then start_i=1 one cycle -> next cycle state_o=1, os_tx_valid_o=1, os_tx_ts2_o=0; all pulses 0.
// - ready=1 always, 2 rx TS1 early -> CONFIG right after the 4th TS1 handshake.
//   Then 2 rx TS2 and 3 post-TS2 handshakes -> done_o=1 once, state_o=0.
// - In ACTIVE: rx TS1, invalid(00), TS1 -> rx_cnt=1; no exit until a 2nd consecutive TS1/TS2 arrives.
// - ready=0 throughout ACTIVE -> timeout_o=1 on cycle 50 after entry, state_o=0, valid drops.
//   Same test in CONFIG -> timeout on cycle 60.
// - Exit condition met while ready=0 -> state holds and os_tx_ts2_o stays 0; transition happens in the first ready=1 cycle.
// - rst_i=1 while in CONFIG -> next cycle all outputs 0, state_o=0; start_i afterwards restarts at ACTIVE with counters 0.

Source files
------------

// File: rtl/ltssm_polling_seq.sv
`default_nettype none
// ============================================================================
// Module  : ltssm_polling_seq
// Purpose : One-lane LTSSM Polling.Active / Polling.Configuration sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module ltssm_polling_seq #(
    parameter int TX_TS1_MIN     = 1024,
    parameter int RX_CONSEC      = 8,
    parameter int TX_TS2_AFTER   = 16,
    parameter int ACTIVE_TIMEOUT = 6000000,
    parameter int CONFIG_TIMEOUT = 12000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       os_tx_valid_o,
    output logic       os_tx_ts2_o,
    input  logic       os_tx_ready_i,
    input  logic       rx_os_valid_i,
    input  logic [1:0] rx_os_type_i,
    output logic [1:0] state_o,
    output logic       done_o,
    output logic       timeout_o
);

    localparam int c_tx1_w   = $clog2(TX_TS1_MIN + 1);
    localparam int c_tx2_w   = $clog2(TX_TS2_AFTER + 1);
    localparam int c_rx_w    = $clog2(RX_CONSEC + 1);
    localparam int c_tmr_max = (ACTIVE_TIMEOUT > CONFIG_TIMEOUT) ? ACTIVE_TIMEOUT : CONFIG_TIMEOUT;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    localparam logic [c_tx1_w-1:0] c_tx1_lim  = c_tx1_w'(TX_TS1_MIN);
    localparam logic [c_tx2_w-1:0] c_tx2_lim  = c_tx2_w'(TX_TS2_AFTER);
    localparam logic [c_rx_w-1:0]  c_rx_lim   = c_rx_w'(RX_CONSEC);
    localparam logic [c_tmr_w-1:0] c_act_last = c_tmr_w'(ACTIVE_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_cfg_last = c_tmr_w'(CONFIG_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CONFIG = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic               valid_q,   valid_d;
    logic               ts2_q,     ts2_d;
    logic               done_q,    done_d;
    logic               timeout_q, timeout_d;
    logic               seen_q,    seen_d;
    logic [c_tx1_w-1:0] tx1_q,     tx1_d;
    logic [c_tx2_w-1:0] tx2_q,     tx2_d;
    logic [c_rx_w-1:0]  rx_q,      rx_d;
    logic [c_tmr_w-1:0] timer_q,   timer_d;

    logic               w_hs;
    logic               w_rx_ts1;
    logic               w_rx_ts2;
    logic [c_tx1_w-1:0] w_tx1_inc;
    logic [c_tx2_w-1:0] w_tx2_inc;
    logic [c_rx_w-1:0]  w_rx_inc;
    logic [c_tmr_w-1:0] w_tmr_inc;

    assign w_hs      = valid_q & os_tx_ready_i;
    assign w_rx_ts1  = rx_os_valid_i & (rx_os_type_i == 2'b01);
    assign w_rx_ts2  = rx_os_valid_i & (rx_os_type_i == 2'b10);
    assign w_tx1_inc = (tx1_q == c_tx1_lim) ? tx1_q : tx1_q + c_tx1_w'(1);
    assign w_tx2_inc = (tx2_q == c_tx2_lim) ? tx2_q : tx2_q + c_tx2_w'(1);
    assign w_rx_inc  = (rx_q == c_rx_lim) ? rx_q : rx_q + c_rx_w'(1);
    assign w_tmr_inc = timer_q + c_tmr_w'(1);

    // Exit checks use this cycle's updated counts so the qualifying handshake itself counts.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        ts2_d     = ts2_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        seen_d    = seen_q;
        tx1_d     = tx1_q;
        tx2_d     = tx2_q;
        rx_d      = rx_q;
        timer_d   = timer_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                ts2_d   = 1'b0;
                seen_d  = 1'b0;
                tx1_d   = '0;
                tx2_d   = '0;
                rx_d    = '0;
                timer_d = '0;
                if (start_i) begin
                    state_d = ST_ACTIVE;
                    valid_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                timer_d = w_tmr_inc;
                if (w_hs) begin
                    tx1_d = w_tx1_inc;
                end
                if (rx_os_valid_i) begin
                    rx_d = (w_rx_ts1 | w_rx_ts2) ? w_rx_inc : '0;
                end
                if (w_hs && (tx1_d >= c_tx1_lim) && (rx_d >= c_rx_lim)) begin
                    state_d = ST_CONFIG;
                    ts2_d   = 1'b1;
                    tx1_d   = '0;
                    rx_d    = '0;
                    timer_d = '0;
                end else if (timer_q == c_act_last) begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            ST_CONFIG: begin
                timer_d = w_tmr_inc;
                if (w_hs && seen_q) begin
                    tx2_d = w_tx2_inc;
                end
                if (w_rx_ts2) begin
                    rx_d   = w_rx_inc;
                    seen_d = 1'b1;
                end else if (rx_os_valid_i) begin
                    rx_d = '0;
                end
                if (w_hs && (tx2_d >= c_tx2_lim) && (rx_d >= c_rx_lim)) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ts2_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (timer_q == c_cfg_last) begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    ts2_d     = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ts2_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            ts2_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            seen_q    <= 1'b0;
            tx1_q     <= '0;
            tx2_q     <= '0;
            rx_q      <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            ts2_q     <= ts2_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            seen_q    <= seen_d;
            tx1_q     <= tx1_d;
            tx2_q     <= tx2_d;
            rx_q      <= rx_d;
            timer_q   <= timer_d;
        end
    end

    assign os_tx_valid_o = valid_q;
    assign os_tx_ts2_o   = ts2_q;
    assign state_o       = state_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ltssm_polling_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ltssm_polling_seq
// Purpose : Scoreboard bench for ltssm_polling_seq with small parameters.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ltssm_polling_seq;

    localparam logic [1:0] c_ts1 = 2'b01;
    localparam logic [1:0] c_ts2 = 2'b10;
    localparam logic [1:0] c_bad = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic       rxv = 1'b0;
    logic [1:0] rxt = 2'b00;
    logic       os_tx_valid_o;
    logic       os_tx_ts2_o;
    logic [1:0] state_o;
    logic       done_o;
    logic       timeout_o;

    ltssm_polling_seq #(
        .TX_TS1_MIN    (4),
        .RX_CONSEC     (2),
        .TX_TS2_AFTER  (3),
        .ACTIVE_TIMEOUT(50),
        .CONFIG_TIMEOUT(60)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .os_tx_valid_o(os_tx_valid_o),
        .os_tx_ts2_o  (os_tx_ts2_o),
        .os_tx_ready_i(ready),
        .rx_os_valid_i(rxv),
        .rx_os_type_i (rxt),
        .state_o      (state_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_to;
        int cyc;
    } ev_t;

    ev_t ev_q[$];
    bit  hs_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] t);
        rxv = v;
        rxt = t;
        step();
        rxv = 1'b0;
        rxt = 2'b00;
    endtask

    task automatic expect_hs(input bit ts2, input int n);
        repeat (n) hs_q.push_back(ts2);
    endtask

    task automatic expect_ev(input bit is_to, input int c);
        ev_t e;
        e.is_to = is_to;
        e.cyc   = c;
        ev_q.push_back(e);
    endtask

    // Snapshot layout: {state, valid, ts2, done, timeout}
    task automatic chk(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {state_o, os_tx_valid_o, os_tx_ts2_o, done_o, timeout_o};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state/valid/ts2/done/to=%b required %b", name, act, exp);
        end
    endtask

    task automatic chk_drained(input string name);
        checks++;
        if (ev_q.size() != 0 || hs_q.size() != 0) begin
            errors++;
            $display("FAIL %s: pending events=%0d handshakes=%0d required 0/0",
                     name, ev_q.size(), hs_q.size());
        end
    endtask

    // Monitor: every TX handshake and every done/timeout pulse is matched against the queues.
    always @(negedge clk) begin
        if (os_tx_valid_o === 1'b1 && ready === 1'b1) begin
            checks++;
            if (hs_q.size() == 0) begin
                errors++;
                $display("FAIL hs_unexpected: got handshake ts2=%b at cyc %0d, required none", os_tx_ts2_o, cyc);
            end else begin
                bit e;
                e = hs_q.pop_front();
                if (os_tx_ts2_o !== e) begin
                    errors++;
                    $display("FAIL hs_type: got ts2=%b at cyc %0d, required %b", os_tx_ts2_o, cyc, e);
                end
            end
        end
        if (done_o === 1'b1 || timeout_o === 1'b1) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL ev_unexpected: got done=%b timeout=%b at cyc %0d, required none", done_o, timeout_o, cyc);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                if ({done_o, timeout_o} !== {~e.is_to, e.is_to} || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL ev_match: got done=%b timeout=%b at cyc %0d, required done=%b timeout=%b at cyc %0d",
                             done_o, timeout_o, cyc, ~e.is_to, e.is_to, e.cyc);
                end
            end
        end
    end

    task automatic do_start(output int t0);
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
    endtask

    // Clean pass; an rx TS2 in the ACTIVE->CONFIG cycle must not count in CONFIG.
    task automatic run_clean(input string tag);
        int t0;
        ready = 1'b1;
        do_start(t0);
        chk({tag, "_first_active"}, {2'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        expect_hs(1'b0, 4);
        expect_hs(1'b1, 4);
        expect_ev(1'b0, t0 + 8);
        drv(1'b1, c_ts1);
        drv(1'b1, c_ts1);
        drv(1'b0, c_bad);
        drv(1'b1, c_ts2);
        chk({tag, "_enter_config"}, {2'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        drv(1'b1, c_ts2);
        drv(1'b1, c_ts2);
        drv(1'b0, c_bad);
        drv(1'b0, c_bad);
        chk({tag, "_done"}, {2'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        drv(1'b0, c_bad);
        chk({tag, "_idle"}, 6'd0);
        chk_drained({tag, "_drained"});
    endtask

    initial begin
        int t0;

        rst = 1'b1;
        repeat (3) step();
        chk("reset", 6'd0);
        rst = 1'b0;
        step();
        chk("post_reset_idle", 6'd0);

        run_clean("clean");

        // Invalid OS breaks the ACTIVE run; TS1 in CONFIG breaks the TS2 run.
        ready = 1'b1;
        do_start(t0);
        expect_hs(1'b0, 7);
        expect_hs(1'b1, 6);
        expect_ev(1'b0, t0 + 13);
        drv(1'b1, c_ts1);
        drv(1'b1, c_bad);
        drv(1'b1, c_ts1);
        drv(1'b0, c_bad);
        drv(1'b0, c_bad);
        drv(1'b0, c_bad);
        chk("rx_break_hold_active", {2'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        drv(1'b1, c_ts1);
        chk("rx_break_enter_config", {2'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        drv(1'b1, c_ts2);
        drv(1'b1, c_ts2);
        drv(1'b1, c_ts1);
        drv(1'b0, c_bad);
        drv(1'b1, c_ts2);
        chk("rx_break_hold_config", {2'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        drv(1'b1, c_ts2);
        drv(1'b0, c_bad);
        chk_drained("rx_break_drained");

        // ACTIVE timeout with TX stalled.
        ready = 1'b0;
        do_start(t0);
        expect_ev(1'b1, t0 + 50);
        repeat (50) drv(1'b1, c_ts1);
        chk("active_timeout", {2'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        drv(1'b0, c_bad);
        chk("active_timeout_after", 6'd0);
        chk_drained("active_timeout_drained");

        // CONFIG timeout with TX stalled after entry.
        ready = 1'b1;
        do_start(t0);
        expect_hs(1'b0, 4);
        expect_ev(1'b1, t0 + 64);
        drv(1'b1, c_ts1);
        drv(1'b1, c_ts1);
        drv(1'b0, c_bad);
        drv(1'b0, c_bad);
        ready = 1'b0;
        chk("cfg_to_enter_config", {2'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        repeat (59) drv(1'b0, c_bad);
        chk("cfg_to_last_cycle", {2'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        drv(1'b0, c_bad);
        chk("config_timeout", {2'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        drv(1'b0, c_bad);
        chk_drained("config_timeout_drained");

        // Exit condition satisfied while TX is stalled: wait for the next handshake.
        ready = 1'b1;
        do_start(t0);
        expect_hs(1'b0, 5);
        expect_hs(1'b1, 4);
        expect_ev(1'b0, t0 + 14);
        repeat (4) drv(1'b0, c_bad);
        ready = 1'b0;
        drv(1'b1, c_ts1);
        drv(1'b1, c_ts1);
        chk("stall_cond_met", {2'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        repeat (3) drv(1'b0, c_bad);
        chk("stall_still_active", {2'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        ready = 1'b1;
        drv(1'b0, c_bad);
        chk("stall_release", {2'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        drv(1'b1, c_ts2);
        drv(1'b1, c_ts2);
        drv(1'b0, c_bad);
        drv(1'b0, c_bad);
        drv(1'b0, c_bad);
        chk_drained("stall_drained");

        // Reset in CONFIG, then a fresh start must behave like a clean run.
        ready = 1'b1;
        do_start(t0);
        expect_hs(1'b0, 4);
        expect_hs(1'b1, 3);
        drv(1'b1, c_ts1);
        drv(1'b1, c_ts1);
        drv(1'b0, c_bad);
        drv(1'b0, c_bad);
        drv(1'b1, c_ts2);
        drv(1'b0, c_bad);
        rst = 1'b1;
        drv(1'b0, c_bad);
        chk("reset_in_config", 6'd0);
        rst = 1'b0;
        drv(1'b0, c_bad);
        chk_drained("reset_drained");
        run_clean("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
